// File: rtl/imm_decode_pkg.sv
// Shared definitions for the immediate decode stage: opcode constants,
// the registered decoded-fields record and a helper that splits an
// instruction word into that record.
package imm_decode_pkg;

  // Primary opcodes (instr[31:26]) the stage knows about
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Everything the stage presents downstream, kept together so the
  // output register and the skid register hold identical records
  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm16;
    logic        signext;
    logic        has_imm;
  } dec_fields_t;

  localparam dec_fields_t DEC_FIELDS_RESET = '0;

  // Split a 32-bit instruction into its fields and attach the
  // extension controls produced by the opcode decoder
  function automatic dec_fields_t split_instr(input logic [31:0] word,
                                              input logic        signext,
                                              input logic        has_imm);
    dec_fields_t f;
    f.opcode  = word[31:26];
    f.rs      = word[25:21];
    f.rt      = word[20:16];
    f.imm16   = word[15:0];
    f.signext = signext;
    f.has_imm = has_imm;
    return f;
  endfunction

endpackage

// File: rtl/imm_decode_stage_opcode_ext_decode.sv
// Purely combinational opcode decoder: tells the sign extender whether the
// instruction carries an immediate and whether it is sign- or zero-extended.
module opcode_ext_decode
  import imm_decode_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       signext,
  output logic       has_imm
);

  // Arithmetic, compare, branch and memory ops sign-extend; logical ops and
  // LUI zero-extend; anything else (including R-type) has no immediate
  always_comb begin
    signext = 1'b0;
    has_imm = 1'b0;
    case (opcode)
      OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
        signext = 1'b1;
        has_imm = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        signext = 1'b0;
        has_imm = 1'b1;
      end
      default: begin
        signext = 1'b0;
        has_imm = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage with valid/ready handshakes on both sides.
// The incoming word is decoded combinationally and the fields plus decode
// results are registered together, so outputs never depend on instr directly.
// Optional feature: define IMM_DECODE_SKID_EN to add a one-entry skid
// register, which makes ready_out a registered signal (no ready_in -> ready_out
// combinational path). Without it, ready_out = ready_in | ~valid_out.
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              flush,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [15:0]       imm16,
  output logic              signext,
  output logic              has_imm
);

  logic        in_signext;
  logic        in_has_imm;
  dec_fields_t in_fields;
  dec_fields_t out_q;
  logic        out_valid_q;
  logic        out_free;
  logic        accept;

  opcode_ext_decode u_opcode_ext_decode (
    .opcode  (instr[31:26]),
    .signext (in_signext),
    .has_imm (in_has_imm)
  );

  assign in_fields = split_instr(instr[31:0], in_signext, in_has_imm);

  // The output register may take a new entry when it is empty or its
  // current entry leaves this cycle
  assign out_free = ~out_valid_q | ready_in;
  assign accept   = valid_in & ready_out;

`ifdef IMM_DECODE_SKID_EN

  dec_fields_t skid_q;
  logic        skid_valid_q;

  assign ready_out = ~skid_valid_q;

  // Output register: a waiting skid entry always goes first so order is kept;
  // only when the skid is empty does a freshly accepted word load directly
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= DEC_FIELDS_RESET;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_q       <= skid_q;
        out_valid_q <= 1'b1;
      end else if (accept) begin
        out_q       <= in_fields;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Skid register: catches a word accepted while the output is stalled and
  // empties as soon as the output register can take it
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_q       <= DEC_FIELDS_RESET;
    end else if (flush) begin
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      skid_valid_q <= 1'b0;
    end else if (accept) begin
      skid_q       <= in_fields;
      skid_valid_q <= 1'b1;
    end
  end

`else

  assign ready_out = out_free;

  // Output register: load on accept, drop the valid bit once the held entry
  // has been taken and nothing new arrived; data bits hold when invalid
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= DEC_FIELDS_RESET;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (out_free) begin
      if (accept) begin
        out_q       <= in_fields;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

`endif

  assign valid_out = out_valid_q;
  assign opcode    = out_q.opcode;
  assign rs        = out_q.rs;
  assign rt        = out_q.rt;
  assign imm16     = out_q.imm16;
  assign signext   = out_q.signext;
  assign has_imm   = out_q.has_imm;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: a queue-based reference model
// compared against the DUT every cycle, directed literal checks, and a long
// randomized run. Follows IMM_DECODE_SKID_EN when it is defined.
module tb_imm_decode_stage;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        valid_in;
  logic        ready_out;
  logic        flush;
  logic        valid_out;
  logic        ready_in;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm16;
  logic        signext;
  logic        has_imm;

  int checks   = 0;
  int failures = 0;
  bit cmpEn    = 1'b0;

  imm_decode_stage #(.DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .flush     (flush),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .imm16     (imm16),
    .signext   (signext),
    .has_imm   (has_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {signext, has_imm} straight from the opcode table
  function automatic logic [1:0] refDecode(input logic [5:0] op);
    if (op inside {6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B})
      return 2'b11;
    if (op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F})
      return 2'b01;
    return 2'b00;
  endfunction

  // Reference model: the stage is a FIFO of held words with capacity 1
  // (or 2 with the skid); lastShown is whatever the output last displayed
  logic [31:0] heldQ[$];
  logic [31:0] lastShown = '0;

  function automatic bit modelReady();
`ifdef IMM_DECODE_SKID_EN
    return heldQ.size() < 2;
`else
    return (heldQ.size() == 0) || ready_in;
`endif
  endfunction

  // Advance the model on each rising edge using the inputs of that cycle
  always @(posedge clk) begin
    bit canTake;
    canTake = modelReady();
    if (reset) begin
      heldQ.delete();
      lastShown = '0;
    end else if (flush) begin
      heldQ.delete();
    end else begin
      if (heldQ.size() > 0 && ready_in) void'(heldQ.pop_front());
      if (valid_in && canTake) heldQ.push_back(instr);
    end
    if (heldQ.size() > 0) lastShown = heldQ[0];
  end

  // Compare DUT outputs to the model on every falling edge
  always @(negedge clk) begin
    logic [31:0] shown;
    logic [33:0] expF;
    logic [33:0] gotF;
    if (cmpEn) begin
      shown = (heldQ.size() > 0) ? heldQ[0] : lastShown;
      expF  = {shown, refDecode(shown[31:26])};
      gotF  = {opcode, rs, rt, imm16, signext, has_imm};
      checks++;
      if (valid_out !== (heldQ.size() > 0)) begin
        failures++;
        $display("[TB] FAIL model_valid t=%0t got=%b want=%b", $time, valid_out, heldQ.size() > 0);
      end
      checks++;
      if (ready_out !== modelReady()) begin
        failures++;
        $display("[TB] FAIL model_ready t=%0t got=%b want=%b", $time, ready_out, modelReady());
      end
      checks++;
      if (gotF !== expF) begin
        failures++;
        $display("[TB] FAIL model_fields t=%0t got=%h want=%h", $time, gotF, expF);
      end
    end
  end

  // Drive one cycle of inputs just after a rising edge
  task automatic applyStimulus(input logic [31:0] i, input logic v, input logic r,
                               input logic f, input logic rst);
    @(posedge clk);
    #1;
    instr    = i;
    valid_in = v;
    ready_in = r;
    flush    = f;
    reset    = rst;
  endtask

  // Literal check of the DUT outputs in the current cycle
  task automatic checkOutput(input string name, input logic expV, input logic expR,
                             input logic [5:0] expOp, input logic [4:0] expRs,
                             input logic [4:0] expRt, input logic [15:0] expImm,
                             input logic expSe, input logic expHi);
    logic [35:0] got;
    logic [35:0] want;
    @(negedge clk);
    #2;
    got  = {valid_out, ready_out, opcode, rs, rt, imm16, signext, has_imm};
    want = {expV, expR, expOp, expRs, expRt, expImm, expSe, expHi};
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got={v,r,op,rs,rt,imm,se,hi}=%h want=%h", name, got, want);
    end
  endtask

  localparam logic [31:0] W_ADDI = 32'h2001FFFB;
  localparam logic [31:0] W_ORI  = 32'h34010008;
  localparam logic [31:0] W_ADD  = 32'h00221820;

  logic [5:0] opPool [14] = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                              6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};

  initial begin
    logic [31:0] stream [8];
    logic [1:0]  d;
    reset    = 1'b1;
    instr    = '0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    flush    = 1'b0;

    applyStimulus('0, 0, 1, 0, 1);
    applyStimulus('0, 0, 1, 0, 0);
    cmpEn = 1'b1;
    checkOutput("reset_state", 0, 1, 6'h00, 5'd0, 5'd0, 16'h0000, 0, 0);

    applyStimulus(W_ADDI, 1, 1, 0, 0);
    applyStimulus('0, 0, 1, 0, 0);
    checkOutput("addi_decode", 1, 1, 6'h08, 5'd0, 5'd1, 16'hFFFB, 1, 1);

    applyStimulus(W_ORI, 1, 1, 0, 0);
    applyStimulus('0, 0, 1, 0, 0);
    checkOutput("ori_decode", 1, 1, 6'h0D, 5'd0, 5'd1, 16'h0008, 0, 1);

    applyStimulus(W_ADD, 1, 1, 0, 0);
    applyStimulus('0, 0, 1, 0, 0);
    checkOutput("rtype_decode", 1, 1, 6'h00, 5'd1, 5'd2, 16'h1820, 0, 0);
    applyStimulus('0, 0, 1, 0, 0);
    checkOutput("drained_hold", 0, 1, 6'h00, 5'd1, 5'd2, 16'h1820, 0, 0);

`ifdef IMM_DECODE_SKID_EN
    applyStimulus(W_ADDI, 1, 0, 0, 0);
    applyStimulus(W_ORI, 1, 0, 0, 0);
    applyStimulus('0, 0, 0, 0, 0);
    checkOutput("skid_full", 1, 0, 6'h08, 5'd0, 5'd1, 16'hFFFB, 1, 1);
    applyStimulus('0, 0, 1, 0, 0);
    checkOutput("skid_release_addi", 1, 0, 6'h08, 5'd0, 5'd1, 16'hFFFB, 1, 1);
    applyStimulus('0, 0, 1, 0, 0);
    checkOutput("skid_release_ori", 1, 1, 6'h0D, 5'd0, 5'd1, 16'h0008, 0, 1);
    applyStimulus('0, 0, 1, 0, 0);
    checkOutput("skid_empty", 0, 1, 6'h0D, 5'd0, 5'd1, 16'h0008, 0, 1);

    applyStimulus(W_ADDI, 1, 0, 0, 0);
    applyStimulus(W_ORI, 1, 0, 0, 0);
`else
    applyStimulus(W_ADDI, 1, 0, 0, 0);
    applyStimulus(W_ORI, 1, 0, 0, 0);
    checkOutput("stall_hold", 1, 0, 6'h08, 5'd0, 5'd1, 16'hFFFB, 1, 1);
`endif
    applyStimulus(W_ADD, 1, 0, 1, 0);
    applyStimulus('0, 0, 0, 0, 0);
    checkOutput("flush_clears", 0, 1, 6'h08, 5'd0, 5'd1, 16'hFFFB, 1, 1);
    applyStimulus('0, 0, 1, 0, 0);
    checkOutput("flush_no_ghost", 0, 1, 6'h08, 5'd0, 5'd1, 16'hFFFB, 1, 1);
    applyStimulus(W_ORI, 1, 1, 1, 0);
    applyStimulus('0, 0, 1, 0, 0);
    checkOutput("flush_beats_accept", 0, 1, 6'h08, 5'd0, 5'd1, 16'hFFFB, 1, 1);

    applyStimulus(W_ORI, 1, 0, 0, 0);
    applyStimulus(W_ADD, 1, 0, 1, 1);
    applyStimulus('0, 0, 1, 0, 0);
    checkOutput("reset_midstream", 0, 1, 6'h00, 5'd0, 5'd0, 16'h0000, 0, 0);
    applyStimulus(W_ADDI, 1, 1, 0, 0);
    applyStimulus('0, 0, 1, 0, 0);
    checkOutput("after_reset_addi", 1, 1, 6'h08, 5'd0, 5'd1, 16'hFFFB, 1, 1);
    applyStimulus('0, 0, 1, 0, 0);

    for (int i = 0; i < 8; i++)
      stream[i] = {opPool[(i * 3 + 1) % 14], 26'($urandom)};
    applyStimulus(stream[0], 1, 1, 0, 0);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(stream[i], 1, 1, 0, 0);
      d = refDecode(stream[i-1][31:26]);
      checkOutput("stream_order", 1, 1, stream[i-1][31:26], stream[i-1][25:21],
                  stream[i-1][20:16], stream[i-1][15:0], d[1], d[0]);
    end
    applyStimulus('0, 0, 1, 0, 0);
    d = refDecode(stream[7][31:26]);
    checkOutput("stream_last", 1, 1, stream[7][31:26], stream[7][25:21],
                stream[7][20:16], stream[7][15:0], d[1], d[0]);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 1) == 0) w[31:26] = opPool[$urandom_range(0, 13)];
      applyStimulus(w, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                    $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
    end
    applyStimulus('0, 0, 1, 0, 0);
    applyStimulus('0, 0, 1, 0, 0);
    applyStimulus('0, 0, 1, 0, 0);
    @(negedge clk);
    #3;
    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
